// File: rtl/tx_source_arbiter_pkg.sv
// Shared types for the TX byte source arbiter: FSM states and fixed source slots.
// No logic; latency and backpressure are properties of the modules that import it.
package tx_source_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLocked = 2'd1,
        StAbort  = 2'd2
    } arb_state_e;

    localparam int unsigned TxSrcTti      = 0;
    localparam int unsigned TxSrcRecovery = 1;

endpackage

// File: rtl/tx_source_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or above ptr, with wrap.
// Zero latency; no handshake, the caller decides when to register the result.
module rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic            found
);

    logic [IdxW-1:0] k;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        k     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = IdxW'((32'(ptr) + i) % N);
            if (!found && req[k]) begin
                gnt[k] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_source_arbiter.sv
// Locks one byte-stream source onto the target FSM TX port per Private Read; counts bytes.
// Grant 1 cycle after xfer_start_i, data path 0 cycles; target ready passes straight to grantee.
module tx_source_arbiter
    import tx_source_arbiter_pkg::*;
#(
    parameter int unsigned NumSrc   = 2,
    parameter int unsigned CntWidth = 16,
    localparam int unsigned SelW    = $clog2(NumSrc)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumSrc*8-1:0]   src_byte_i,
    input  logic [NumSrc-1:0]     src_last_i,
    input  logic [NumSrc-1:0]     src_valid_i,
    output logic [NumSrc-1:0]     src_ready_o,
    output logic [NumSrc-1:0]     src_err_o,
    input  logic                  xfer_start_i,
    input  logic                  xfer_end_i,
    input  logic                  force_en_i,
    input  logic [SelW-1:0]       force_sel_i,
    output logic [7:0]            tx_byte_o,
    output logic                  tx_byte_last_o,
    output logic                  tx_byte_valid_o,
    input  logic                  tx_byte_ready_i,
    input  logic                  tx_byte_err_i,
    output logic [NumSrc-1:0]     grant_o,
    output logic                  busy_o,
    output logic [CntWidth-1:0]   xfer_bytes_o,
    output logic                  xfer_done_o,
    output logic                  xfer_aborted_o
);

    arb_state_e            state_q, state_d;
    logic [NumSrc-1:0]     grant_q, grant_d;
    logic [SelW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CntWidth-1:0]   byte_cnt_q, byte_cnt_d;
    logic [CntWidth-1:0]   xfer_bytes_q, xfer_bytes_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;

    logic [NumSrc-1:0]     rr_gnt;
    logic                  rr_found;
    logic [SelW-1:0]       rr_idx;
    logic [NumSrc-1:0]     force_gnt;
    logic                  force_ok;

    logic                  locked;
    logic [7:0]            sel_byte;
    logic                  sel_last;
    logic                  sel_valid;
    logic                  accept;
    logic                  last_accept;
    logic [CntWidth-1:0]   cnt_inc;

    rr_arbiter #(
        .N (NumSrc)
    ) u_rr (
        .req   (src_valid_i),
        .ptr   (rr_ptr_q),
        .gnt   (rr_gnt),
        .found (rr_found)
    );

    always_comb begin
        rr_idx = '0;
        for (int unsigned i = 0; i < NumSrc; i++) begin
            if (rr_gnt[i]) begin
                rr_idx = SelW'(i);
            end
        end
    end

    // Non-power-of-two NumSrc leaves unused force_sel_i codes; those grant nothing.
    assign force_ok  = (32'(force_sel_i) < NumSrc);
    assign force_gnt = NumSrc'(1) << force_sel_i;

    always_comb begin
        sel_byte  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int unsigned i = 0; i < NumSrc; i++) begin
            if (grant_q[i]) begin
                sel_byte  = src_byte_i[i*8 +: 8];
                sel_last  = src_last_i[i];
                sel_valid = src_valid_i[i];
            end
        end
    end

    assign locked          = (state_q == StLocked);
    assign tx_byte_o       = locked ? sel_byte : 8'h00;
    assign tx_byte_last_o  = locked & sel_last;
    assign tx_byte_valid_o = locked & sel_valid;
    assign accept          = tx_byte_valid_o & tx_byte_ready_i;
    assign last_accept     = accept & tx_byte_last_o;
    assign src_ready_o     = accept ? grant_q : '0;
    assign src_err_o       = (state_q == StAbort) ? grant_q : '0;

    assign grant_o         = grant_q;
    assign busy_o          = (state_q != StIdle);
    assign xfer_bytes_o    = xfer_bytes_q;
    assign xfer_done_o     = done_q;
    assign xfer_aborted_o  = aborted_q;

    assign cnt_inc = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + CntWidth'(1);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        byte_cnt_d   = byte_cnt_q;
        xfer_bytes_d = xfer_bytes_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                grant_d = '0;
                if (xfer_start_i) begin
                    if (force_en_i) begin
                        if (force_ok) begin
                            grant_d    = force_gnt;
                            byte_cnt_d = '0;
                            state_d    = StLocked;
                        end
                    end else if (rr_found) begin
                        grant_d    = rr_gnt;
                        byte_cnt_d = '0;
                        rr_ptr_d   = (rr_idx == SelW'(NumSrc - 1)) ? '0 : rr_idx + SelW'(1);
                        state_d    = StLocked;
                    end
                end
            end
            StLocked: begin
                // A bus error wins over a last byte accepted in the same cycle.
                if (tx_byte_err_i || (xfer_end_i && !last_accept)) begin
                    xfer_bytes_d = byte_cnt_q;
                    done_d       = 1'b1;
                    aborted_d    = 1'b1;
                    state_d      = StAbort;
                end else if (accept) begin
                    byte_cnt_d = cnt_inc;
                    if (tx_byte_last_o) begin
                        xfer_bytes_d = cnt_inc;
                        done_d       = 1'b1;
                        grant_d      = '0;
                        state_d      = StIdle;
                    end
                end
            end
            StAbort: begin
                grant_d = '0;
                state_d = StIdle;
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            byte_cnt_q   <= '0;
            xfer_bytes_q <= '0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            byte_cnt_q   <= byte_cnt_d;
            xfer_bytes_q <= xfer_bytes_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

endmodule

// File: tb/tb_tx_source_arbiter.sv
// Bench for tx_source_arbiter: queue-backed sources, expected bytes/grants/results scoreboarded.
module tb_tx_source_arbiter;
    import tx_source_arbiter_pkg::*;

    localparam int NS = 2;
    localparam int CW = 16;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NS*8-1:0]   src_byte_i = '0;
    logic [NS-1:0]     src_last_i = '0;
    logic [NS-1:0]     src_valid_i = '0;
    logic [NS-1:0]     src_ready_o;
    logic [NS-1:0]     src_err_o;
    logic              xfer_start_i = 1'b0;
    logic              xfer_end_i = 1'b0;
    logic              force_en_i = 1'b0;
    logic [0:0]        force_sel_i = '0;
    logic [7:0]        tx_byte_o;
    logic              tx_byte_last_o;
    logic              tx_byte_valid_o;
    logic              tx_byte_ready_i = 1'b1;
    logic              tx_byte_err_i = 1'b0;
    logic [NS-1:0]     grant_o;
    logic              busy_o;
    logic [CW-1:0]     xfer_bytes_o;
    logic              xfer_done_o;
    logic              xfer_aborted_o;

    tx_source_arbiter #(.NumSrc(NS), .CntWidth(CW)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .src_byte_i      (src_byte_i),
        .src_last_i      (src_last_i),
        .src_valid_i     (src_valid_i),
        .src_ready_o     (src_ready_o),
        .src_err_o       (src_err_o),
        .xfer_start_i    (xfer_start_i),
        .xfer_end_i      (xfer_end_i),
        .force_en_i      (force_en_i),
        .force_sel_i     (force_sel_i),
        .tx_byte_o       (tx_byte_o),
        .tx_byte_last_o  (tx_byte_last_o),
        .tx_byte_valid_o (tx_byte_valid_o),
        .tx_byte_ready_i (tx_byte_ready_i),
        .tx_byte_err_i   (tx_byte_err_i),
        .grant_o         (grant_o),
        .busy_o          (busy_o),
        .xfer_bytes_o    (xfer_bytes_o),
        .xfer_done_o     (xfer_done_o),
        .xfer_aborted_o  (xfer_aborted_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    logic [8:0]  src_q [NS][$];
    logic [8:0]  exp_byte_q [$];
    logic [1:0]  exp_grant_q [$];
    logic [16:0] exp_done_q [$];
    logic [1:0]  exp_err_q [$];
    logic [NS-1:0] acc = '0;
    logic busy_prev = 1'b0;

    localparam logic [1:0] G0 = 2'(1 << TxSrcTti);
    localparam logic [1:0] G1 = 2'(1 << TxSrcRecovery);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: unexpected event, value 0x%0h", name, act);
    endtask

    // Source model: pop on the accept seen at the previous negedge, then present the new head.
    always @(posedge clk_i) begin
        #2;
        for (int s = 0; s < NS; s++) begin
            if (acc[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
            if (src_q[s].size() > 0) begin
                src_valid_i[s]       = 1'b1;
                src_byte_i[s*8 +: 8] = src_q[s][0][7:0];
                src_last_i[s]        = src_q[s][0][8];
            end else begin
                src_valid_i[s]       = 1'b0;
                src_byte_i[s*8 +: 8] = 8'h00;
                src_last_i[s]        = 1'b0;
            end
        end
    end

    // Monitor: compares DUT events against the expectation queues.
    always @(negedge clk_i) begin
        acc = src_valid_i & src_ready_o;
        if (tx_byte_valid_o && tx_byte_ready_i) begin
            if (exp_byte_q.size() == 0) unexpected("tx_byte", 32'({tx_byte_last_o, tx_byte_o}));
            else check("tx_byte", 32'({tx_byte_last_o, tx_byte_o}), 32'(exp_byte_q.pop_front()));
        end
        if (busy_o && !busy_prev) begin
            if (exp_grant_q.size() == 0) unexpected("grant", 32'(grant_o));
            else check("grant", 32'(grant_o), 32'(exp_grant_q.pop_front()));
        end
        if (xfer_done_o) begin
            if (exp_done_q.size() == 0) unexpected("xfer_done", 32'({xfer_aborted_o, xfer_bytes_o}));
            else check("xfer_done", 32'({xfer_aborted_o, xfer_bytes_o}), 32'(exp_done_q.pop_front()));
        end
        if (src_err_o != '0) begin
            if (exp_err_q.size() == 0) unexpected("src_err", 32'(src_err_o));
            else check("src_err", 32'(src_err_o), 32'(exp_err_q.pop_front()));
        end
        busy_prev = busy_o;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk_i);
    endtask

    task automatic pulse_start();
        xfer_start_i = 1'b1;
        tick();
        xfer_start_i = 1'b0;
    endtask

    // n bytes on source s, last flag on the final one; the first nexp are expected on tx.
    task automatic load(input int s, input int n, input logic [7:0] base, input int nexp);
        for (int i = 0; i < n; i++) begin
            src_q[s].push_back({(i == n - 1), base + 8'(i)});
            if (i < nexp) exp_byte_q.push_back({(i == n - 1), base + 8'(i)});
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, 32'(grant_o), 32'h0);
        check({tag, "_busy"}, 32'(busy_o), 32'h0);
        check({tag, "_tx_valid"}, 32'(tx_byte_valid_o), 32'h0);
        check({tag, "_src_ready"}, 32'(src_ready_o), 32'h0);
        check({tag, "_src_err"}, 32'(src_err_o), 32'h0);
        check({tag, "_done"}, 32'(xfer_done_o), 32'h0);
        check({tag, "_bytes"}, 32'(xfer_bytes_o), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk_i);
        at_neg();
        check_idle_outputs("reset");
        tick();
        rst_ni = 1'b1;
        tick();

        // Round-robin rotation over three one-byte transfers.
        load(0, 1, 8'hB0, 1);
        load(1, 1, 8'hB1, 1);
        load(0, 1, 8'hB2, 1);
        exp_grant_q.push_back(G0); exp_grant_q.push_back(G1); exp_grant_q.push_back(G0);
        repeat (3) exp_done_q.push_back({1'b0, 16'd1});
        tick();
        pulse_start(); tick();
        pulse_start(); tick();
        pulse_start(); tick(); tick();

        // Four-byte stream on src0, back-to-back.
        load(0, 4, 8'hA0, 4);
        exp_grant_q.push_back(G0);
        exp_done_q.push_back({1'b0, 16'd4});
        tick();
        pulse_start();
        at_neg();
        check("first_byte_valid", 32'(tx_byte_valid_o), 32'h1);
        check("first_byte_src_ready", 32'(src_ready_o), 32'(G0));
        repeat (4) tick();
        at_neg();
        check("stream_done_timing", 32'(xfer_done_o), 32'h1);
        check("stream_grant_released", 32'(grant_o), 32'h0);
        tick();

        // No source valid: no grant, no result.
        pulse_start();
        at_neg();
        check("noreq_grant", 32'(grant_o), 32'h0);
        check("noreq_busy", 32'(busy_o), 32'h0);
        check("noreq_tx_valid", 32'(tx_byte_valid_o), 32'h0);
        repeat (3) tick();
        at_neg();
        check("noreq_done", 32'(xfer_done_o), 32'h0);
        tick();

        // Bus error on the third accept of an 8-byte src1 stream.
        load(1, 8, 8'hC0, 3);
        exp_grant_q.push_back(G1);
        exp_done_q.push_back({1'b1, 16'd2});
        exp_err_q.push_back(G1);
        tick();
        pulse_start();
        tick();
        tick();
        tx_byte_err_i = 1'b1;
        tick();
        tx_byte_err_i = 1'b0;
        at_neg();
        check("abort_src_err", 32'(src_err_o), 32'(G1));
        check("abort_busy", 32'(busy_o), 32'h1);
        check("abort_tx_valid", 32'(tx_byte_valid_o), 32'h0);
        check("abort_flag", 32'(xfer_aborted_o), 32'h1);
        tick();
        at_neg();
        check("abort_idle_busy", 32'(busy_o), 32'h0);
        check("abort_err_single", 32'(src_err_o), 32'h0);
        tick();
        src_q[1].delete();
        tick();

        // Normal src0 transfer moves the pointer to src1.
        load(0, 1, 8'hD0, 1);
        exp_grant_q.push_back(G0);
        exp_done_q.push_back({1'b0, 16'd1});
        tick();
        pulse_start(); tick(); tick();

        // Forced grant to an idle src1 stalls, then xfer_end_i aborts it.
        load(0, 1, 8'hD1, 0);
        force_en_i  = 1'b1;
        force_sel_i = 1'b1;
        exp_grant_q.push_back(G1);
        exp_done_q.push_back({1'b1, 16'd0});
        exp_err_q.push_back(G1);
        tick();
        pulse_start();
        at_neg();
        check("force_grant", 32'(grant_o), 32'(G1));
        check("force_stall_valid", 32'(tx_byte_valid_o), 32'h0);
        check("force_stall_ready", 32'(src_ready_o), 32'h0);
        tick(); tick();
        xfer_end_i = 1'b1;
        tick();
        xfer_end_i = 1'b0;
        force_en_i = 1'b0;
        tick(); tick();

        // Pointer untouched by the forced grant: src1 still has priority.
        load(1, 1, 8'hE0, 1);
        exp_grant_q.push_back(G1);
        exp_done_q.push_back({1'b0, 16'd1});
        tick();
        pulse_start(); tick(); tick();

        // Reset while locked and stalled.
        tx_byte_ready_i = 1'b0;
        exp_grant_q.push_back(G0);
        pulse_start();
        at_neg();
        check("pre_reset_busy", 32'(busy_o), 32'h1);
        tick();
        rst_ni = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        tick();
        rst_ni = 1'b1;
        tx_byte_ready_i = 1'b1;
        load(1, 1, 8'hF0, 0);
        exp_byte_q.push_back({1'b1, 8'hD1});
        exp_grant_q.push_back(G0);
        exp_done_q.push_back({1'b0, 16'd1});
        tick();
        pulse_start(); tick(); tick(); tick();

        check("leftover_bytes", 32'(exp_byte_q.size()), 32'h0);
        check("leftover_grants", 32'(exp_grant_q.size()), 32'h0);
        check("leftover_done", 32'(exp_done_q.size()), 32'h0);
        check("leftover_err", 32'(exp_err_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tx_source_arbiter.md
# tx_source_arbiter

Shares the target FSM's single TX byte interface between several byte-stream requesters for I3C Private Reads, e.g. the TTI TX descriptor path and the recovery-mode TX path. It grants one source per read transfer and locks the grant until the source's last byte is accepted or the transfer is aborted. It reports per-transfer byte counts. It sits between the TX byte producers and the target FSM.

## Interface
- NumSrc, 2: number of requesting sources (2..8).
- CntWidth, 16: width of the per-transfer byte counter.
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- src_byte_i  in  NumSrc×8  per-source data byte
- src_last_i  in  NumSrc  per-source "this byte is last"
- src_valid_i  in  NumSrc  per-source byte valid
- src_ready_o  out  NumSrc  per-source byte accepted (grantee only)
- src_err_o  out  NumSrc  one-cycle abort pulse to the grantee
- xfer_start_i  in  1  pulse from target FSM: Private Read addressed, arbitrate now
- xfer_end_i  in  1  pulse from target FSM: STOP/Sr seen
- force_en_i  in  1  bypass arbitration, always grant force_sel_i
- force_sel_i  in  $clog2(NumSrc)  forced source index
- tx_byte_o  out  8  byte to target FSM
- tx_byte_last_o  out  1  last byte of transfer
- tx_byte_valid_o  out  1  byte valid
- tx_byte_ready_i  in  1  target FSM consumed byte
- tx_byte_err_i  in  1  target FSM bus error, abort transfer
- grant_o  out  NumSrc  one-hot current grant (0 when idle)
- busy_o  out  1  transfer locked
- xfer_bytes_o  out  CntWidth  bytes accepted in the last finished transfer
- xfer_done_o  out  1  one-cycle pulse when xfer_bytes_o updates
- xfer_aborted_o  out  1  qualifies xfer_done_o: transfer ended by error or early end

## Operation
- FSM states: IDLE, LOCKED, ABORT.
- IDLE:
  - On xfer_start_i, compute a candidate.
  - If force_en_i is set, the candidate is force_sel_i regardless of its valid.
  - Otherwise, round-robin over sources with src_valid_i=1, searching from rr_ptr upward with wrap.
  - If a candidate exists: register grant, go to LOCKED, and set rr_ptr to winner+1 (mod NumSrc). A forced grant leaves rr_ptr unchanged.
  - If no candidate exists: stay IDLE with grant 0. tx_byte_valid_o stays 0, so the target NACKs.
- LOCKED:
  - tx_byte_o, tx_byte_last_o and tx_byte_valid_o are combinational copies of the grantee's inputs.
  - src_ready_o[g] = tx_byte_valid_o & tx_byte_ready_i. All other src_ready_o are 0.
  - Each accept increments byte_cnt. byte_cnt saturates at all-ones and clears on entry to LOCKED.
  - An accept with last=1 ends the transfer normally: go to IDLE, pulse xfer_done_o, xfer_aborted_o=0.
- Abort: in LOCKED, tx_byte_err_i or xfer_end_i without a completed last byte.
  - Go to ABORT.
  - In ABORT, src_err_o[g]=1 for exactly one cycle, tx_byte_valid_o=0, xfer_done_o=1, xfer_aborted_o=1.
  - Next cycle: IDLE.
- Priority within one cycle:
  - tx_byte_err_i beats an accepted last byte, and the result is an abort.
  - Accepted last byte together with xfer_end_i is a normal completion.
- xfer_start_i while LOCKED or ABORT is ignored.
- xfer_end_i in IDLE is ignored.
- xfer_bytes_o holds its value until the next xfer_done_o.
- The count includes the last byte. On abort it counts the bytes accepted before the abort.
- A grantee dropping src_valid_i mid-transfer keeps the lock; the transfer just stalls.

## Timing
- Grant latency: xfer_start_i at cycle N gives grant_o/busy_o at N+1. The first byte can be accepted at N+1.
- Data path is zero latency (combinational mux): no bubbles, one byte per cycle.
- Last accept at cycle M: grant_o=0 and xfer_done_o=1 at M+1. A new xfer_start_i is honoured at M+1.
- Abort detected at cycle M: src_err_o and xfer_done_o at M+1, IDLE at M+2.
- Reset values: all outputs 0; state IDLE; rr_ptr 0; byte_cnt 0.
- Reset mid-transfer drops the grant immediately, with no error pulse.

## Structure
- Shared package holds:
  - the state enum (IDLE, LOCKED, ABORT);
  - the source index constants TxSrcTti=0 and TxSrcRecovery=1.
- One natural sub-module: rr_arbiter (combinational round-robin pick from a request vector plus pointer, returning a one-hot grant and a found flag). It is reusable elsewhere.
- Everything else lives in tx_source_arbiter.

## Test plan
- Src0 valid with a 4-byte stream, last on the 4th byte; pulse xfer_start_i; ready held 1 -> grant_o=01 next cycle, 4 bytes out on consecutive cycles, xfer_done_o with xfer_bytes_o=4 and aborted=0.
- Both sources valid for three consecutive 1-byte transfers -> grants 01, 10, 01 (round-robin rotates).
- No source valid at xfer_start_i -> grant_o stays 0, tx_byte_valid_o=0, no xfer_done_o.
- Src1 streams 8 bytes; tx_byte_err_i at the 3rd accept -> src_err_o[1] pulses once, xfer_bytes_o=2, aborted=1, IDLE two cycles later.
- force_en_i=1 with force_sel_i=1, only src0 valid -> src1 is granted and the output stalls. xfer_end_i then aborts with xfer_bytes_o=0, and rr_ptr is unchanged.
- Reset asserted mid-transfer -> all outputs 0 asynchronously; after release the next xfer_start_i arbitrates from src0.
